qpp_interleave_reader: RTL and testbench
========================================

// Module: qpp_interleave_reader
// PURPOSE
//  Read-side controller for the 2-bit-wide dual-port interleaver RAM of the turbo encoder.
//  On start, it walks one block of K entries in QPP order: pi(i) = (f1*i + f2*i^2) mod K, i = 0..K-1.
//  It drives the RAM's read port (port B, write enable tied low) and streams the 2-bit words out.
//  The output stream uses a valid/ready handshake and feeds the second constituent encoder.
// PARAMETERS
//  ADDR_W  12    width of RAM address, K, f1 and f2
//  DEPTH   2396  RAM depth; largest legal K
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       1-cycle pulse; latches k, f1, f2; ignored while busy=1
//  k          in   ADDR_W  block length, legal range 1..DEPTH
//  f1, f2     in   ADDR_W  QPP coefficients; both must be < k
//  ram_addr   out  ADDR_W  RAM read address (port B)
//  ram_we     out  1       constant 0
//  ram_rdata  in   2       RAM read data, valid 1 cycle after the address
//  out_data   out  2       interleaved word
//  out_valid  out  1       out_data valid
//  out_ready  in   1       downstream accept
//  out_last   out  1       high with the word for i = K-1
//  busy       out  1       high from LOAD until the last word is accepted
//  done       out  1       1-cycle pulse on the cycle after the last handshake
//  cfg_err    out  1       1-cycle pulse: start with k=0, k>DEPTH, f1>=k or f2>=k
// BEHAVIOUR
//  Reset values: all outputs 0, FSM in IDLE, skid buffer empty.
//  FSM states: IDLE -> LOAD -> RUN -> DRAIN -> IDLE.
//  IDLE
//   - On start with an illegal config: pulse cfg_err and stay in IDLE.
//   - On start with a legal config: latch k, f1, f2 and go to LOAD.
//  LOAD (1 cycle), all sums computed with ADDR_W+1 bits:
//   - pi = 0
//   - g  = (f1+f2) mod K
//   - d  = (2*f2) mod K
//   - "mod K" of a sum below 2K is one conditional subtract: s >= K ? s-K : s.
//  RUN
//   - Issue one read per cycle (ram_addr = pi) when the skid buffer has room for the
//     in-flight word, counting words in flight.
//   - After each issue: pi <= (pi+g) mod K, g <= (g+d) mod K, issue counter i++.
//   - After issuing i = K-1, go to DRAIN.
//  DRAIN: stay until the final word completes its handshake; pulse done; go to IDLE.
//  Skid buffer: 2 entries. Reads issue only while (entries held + reads in flight) < 2.
//   Together with the 1-cycle RAM latency this gives no loss and no duplication
//   under any out_ready pattern.
//  Throughput: 1 word/cycle with out_ready held high. The first out_valid appears
//   3 cycles after start (LOAD, issue, data).
//  out_data/out_valid/out_last stay stable while out_valid=1 and out_ready=0.
//  out_last is asserted only on the word for i = K-1.
//  K=1: a single read of address 0, out_last on that word.
//  start during busy: ignored; no state change and no cfg_err.
//  Reset mid-block: everything clears immediately; no done pulse; the partial block is discarded.
//  The block never writes the RAM; the write side owns port A.
// CONFIGURATION
//  INTLV_BYPASS_EN defined:
//   - Adds input port bypass (1 bit), latched on start.
//   - bypass=1: read linear order pi(i) = i; f1/f2 are not checked and not used.
//   - bypass=0: QPP order as above.
//   - Timing and handshake are identical in both orders.
//  INTLV_BYPASS_EN undefined: no bypass port; QPP order always.
// TESTING
//  1 Reset, then start k=40, f1=3, f2=10, out_ready=1
//     -> addresses 0, 13, 6, 19, ...; 40 words, all 40 addresses distinct;
//        out_last on word 40; done 1 cycle after it.
//  2 Same config, out_ready random at 50%
//     -> same 40-word sequence, no drop or duplicate, outputs held stable while stalled.
//  3 start with k=0, then with k=2397, then k=40/f2=40
//     -> cfg_err pulse each time; busy stays 0; no RAM reads.
//  4 k=1 -> one word from address 0 with out_last=1; done pulse.
//  5 Assert rst at word 20 of a k=40 block
//     -> all outputs 0 next cycle, no done; a new start runs cleanly from pi=0.
//  6 INTLV_BYPASS_EN defined, bypass=1, k=8 -> addresses 0..7 in order; out_last on address 7.

Source files
------------

// File: rtl/qpp_interleave_reader.sv
`default_nettype none
// ============================================================================
// Module   : qpp_interleave_reader
// Brief    : Walks one turbo-interleaver block in QPP order over RAM port B and
//            streams the 2-bit words out through a 2-entry skid buffer.
//            Optional macro INTLV_BYPASS_EN adds i_bypass (linear read order).
// Revision : 1.0 - initial release
// ============================================================================
module qpp_interleave_reader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2396
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_k,
    input  logic [ADDR_W-1:0] i_f1,
    input  logic [ADDR_W-1:0] i_f2,
`ifdef INTLV_BYPASS_EN
    input  logic              i_bypass,
`endif
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    input  logic [1:0]        i_ram_rdata,
    output logic [1:0]        o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_f1;
    logic [ADDR_W-1:0] r_f2;
    logic              r_bypass;
    logic [ADDR_W-1:0] r_pi;
    logic [ADDR_W-1:0] r_g;
    logic [ADDR_W-1:0] r_d;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_inflight;
    logic              r_inf_last;
    logic [1:0]        r_buf_data [0:1];
    logic              r_buf_last [0:1];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_held;
    logic              r_done;
    logic              r_cfg_err;

    logic              w_bypass_in;
    logic              w_cfg_bad;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_last_issue;

`ifdef INTLV_BYPASS_EN
    assign w_bypass_in = i_bypass;
`else
    assign w_bypass_in = 1'b0;
`endif

    // Sum of two residues is below 2K, so one conditional subtract reduces it.
    function automatic logic [ADDR_W-1:0] f_mod_add(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b,
        input logic [ADDR_W-1:0] m
    );
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[ADDR_W-1:0];
    endfunction

    assign w_cfg_bad = (i_k == '0) || ({1'b0, i_k} > c_DEPTH) ||
                       (!w_bypass_in && ((i_f1 >= i_k) || (i_f2 >= i_k)));

    assign o_out_valid = (r_held != 2'd0);
    assign o_out_data  = o_out_valid ? r_buf_data[r_rd_ptr] : 2'b00;
    assign o_out_last  = o_out_valid & r_buf_last[r_rd_ptr];
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_cfg_err   = r_cfg_err;
    assign o_ram_we    = 1'b0;

    assign w_pop  = o_out_valid & i_out_ready;
    assign w_push = r_inflight;

    // A word popped this cycle frees its slot in time for a read issued now.
    assign w_occ        = {1'b0, r_held} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_RUN) && (w_occ < 3'd2);
    assign w_last_issue = (r_cnt == (r_k - ADDR_W'(1)));
    assign o_ram_addr   = w_issue ? r_pi : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_f1          <= '0;
            r_f2          <= '0;
            r_bypass      <= 1'b0;
            r_pi          <= '0;
            r_g           <= '0;
            r_d           <= '0;
            r_cnt         <= '0;
            r_inflight    <= 1'b0;
            r_inf_last    <= 1'b0;
            r_buf_data[0] <= 2'b00;
            r_buf_data[1] <= 2'b00;
            r_buf_last[0] <= 1'b0;
            r_buf_last[1] <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_held        <= 2'd0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_inflight <= w_issue;
            r_inf_last <= w_issue & w_last_issue;

            if (w_push) begin
                r_buf_data[r_wr_ptr] <= i_ram_rdata;
                r_buf_last[r_wr_ptr] <= r_inf_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_held <= r_held + {1'b0, w_push} - {1'b0, w_pop};

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_k      <= i_k;
                            r_f1     <= i_f1;
                            r_f2     <= i_f2;
                            r_bypass <= w_bypass_in;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_pi  <= '0;
                    r_cnt <= '0;
                    if (r_bypass) begin
                        r_g <= f_mod_add(ADDR_W'(1), '0, r_k);
                        r_d <= '0;
                    end else begin
                        r_g <= f_mod_add(r_f1, r_f2, r_k);
                        r_d <= f_mod_add(r_f2, r_f2, r_k);
                    end
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_pi  <= f_mod_add(r_pi, r_g, r_k);
                        r_g   <= f_mod_add(r_g, r_d, r_k);
                        r_cnt <= r_cnt + ADDR_W'(1);
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && o_out_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpp_interleave_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpp_interleave_reader
// Brief    : Scoreboard bench for qpp_interleave_reader with a 1-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qpp_interleave_reader;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2396;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] k = '0;
    logic [ADDR_W-1:0] f1 = '0;
    logic [ADDR_W-1:0] f2 = '0;
    logic              bypass = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [1:0]        ram_rdata = 2'b00;
    logic [1:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              cfg_err;

    logic [1:0]  mem [0:(1<<ADDR_W)-1];
    logic [2:0]  exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          done_cnt = 0;
    int          last_hs_cyc = -10;
    int          rdy_mode = 0;
    logic        prev_stall = 1'b0;
    logic [2:0]  prev_word = 3'b000;

    qpp_interleave_reader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_k         (k),
        .i_f1        (f1),
        .i_f2        (f2),
`ifdef INTLV_BYPASS_EN
        .i_bypass    (bypass),
`endif
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .i_ram_rdata (ram_rdata),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_last  (out_last),
        .o_busy      (busy),
        .o_done      (done),
        .o_cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pop, stall stability and done timing.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_word", 32'({out_last, out_data}), 32'(prev_word));
            end
            if (done) begin
                chk("done_timing", 32'(cyc), 32'(last_hs_cyc + 1));
                chk("done_busy", 32'(busy), 32'd0);
                done_cnt++;
            end
            if (out_valid && out_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'({out_last, out_data}), 32'hFFFF);
                end else begin
                    chk("word", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                end
                if (out_last) last_hs_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    task automatic fill_mem(input int sel, input int salt);
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            mem[a] = 2'(((a >> (2 * sel)) ^ salt) & 3);
        end
    endtask

    task automatic push_expect(input int kk, input int ff1, input int ff2, input bit byp,
                               input int sel, input int salt);
        for (int i = 0; i < kk; i++) begin
            longint p;
            p = byp ? longint'(i) : (longint'(ff1) * i + longint'(ff2) * i * i) % kk;
            exp_q.push_back({(i == kk - 1), 2'(((p >> (2 * sel)) ^ salt) & 3)});
        end
    endtask

    task automatic pulse_start(input int kk, input int ff1, input int ff2, input bit byp);
        @(posedge clk);
        #1;
        k = ADDR_W'(kk); f1 = ADDR_W'(ff1); f2 = ADDR_W'(ff2); bypass = byp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_block(input int kk, input int ff1, input int ff2, input bit byp,
                             input int sel, input int salt, input int rmode, input bit inject);
        int s_cyc;
        int d0;
        bit seen;
        fill_mem(sel, salt);
        rdy_mode = rmode;
        push_expect(kk, ff1, ff2, byp, sel, salt);
        d0 = done_cnt;
        pulse_start(kk, ff1, ff2, byp);
        s_cyc = cyc;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("first_valid_latency", seen ? 32'(cyc - s_cyc) : 32'hFFFF, 32'd3);
        if (inject) begin
            pulse_start(0, 0, 0, 1'b0);
            @(negedge clk);
            chk("start_while_busy_cfg_err", 32'(cfg_err), 32'd0);
            chk("start_while_busy_busy", 32'(busy), 32'd1);
        end
        seen = 1'b0;
        for (int t = 0; t < 4 * kk + 60 && !seen; t++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) seen = 1'b1;
        end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic cfg_bad(input int kk, input int ff1, input int ff2);
        pulse_start(kk, ff1, ff2, 1'b0);
        @(negedge clk);
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        chk("cfg_err_busy", 32'(busy), 32'd0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("cfg_err_after", 32'({cfg_err, busy, out_valid}), 32'd0);
            chk("cfg_no_read", 32'(ram_addr), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 32'({out_valid, out_last, out_data, busy, done, cfg_err, ram_we}), 32'd0);
        chk({name, "_addr"}, 32'(ram_addr), 32'd0);
    endtask

    initial begin
        int d0;
        int h0;
        int t;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // In-order rate: six passes expose two address bits each.
        for (int s = 0; s < 6; s++) run_block(40, 3, 10, 1'b0, s, 0, 0, 1'b0);
        // Random backpressure, with a stray start during the first pass.
        for (int s = 0; s < 6; s++) run_block(40, 3, 10, 1'b0, s, 1, 1, s == 0);

        cfg_bad(0, 0, 0);
        cfg_bad(2397, 3, 10);
        cfg_bad(40, 3, 40);

        run_block(1, 0, 0, 1'b0, 0, 2, 0, 1'b0);
        run_block(5, 1, 2, 1'b0, 0, 0, 1, 1'b0);

        // Reset in the middle of a block.
        fill_mem(0, 0);
        push_expect(40, 3, 10, 1'b0, 0, 0);
        h0 = hs_count;
        d0 = done_cnt;
        pulse_start(40, 3, 10, 1'b0);
        t = 0;
        while (hs_count < h0 + 20 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("reached_word_20", 32'(hs_count - h0), 32'd20);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_all_zero("reset_mid_immediate");
        @(negedge clk);
        check_all_zero("reset_mid_next");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        chk("idle_after_reset", 32'({busy, out_valid}), 32'd0);
        run_block(40, 3, 10, 1'b0, 0, 0, 0, 1'b0);
        run_block(40, 3, 10, 1'b0, 1, 0, 0, 1'b0);

`ifdef INTLV_BYPASS_EN
        for (int s = 0; s < 2; s++) run_block(8, 9, 50, 1'b1, s, 0, 0, 1'b0);
        run_block(8, 1, 2, 1'b1, 0, 3, 1, 1'b0);
        run_block(8, 3, 2, 1'b0, 0, 0, 0, 1'b0);
`endif

        chk("ram_we_low", 32'(ram_we), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
